pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
Consumer end of the hazard-detect signal. Combines the ID-stage hazard request, the EXE-stage taken-branch, and the MEM-stage cache/SRAM ready signal into the pipeline's freeze, bubble and flush controls. Tracks the current pipeline condition in a registered state machine. Keeps saturating performance counters and a sticky stall watchdog. Sits between the hazard unit, the branch/status logic, the cache controller, and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.

Parameters:
CNT_W, 16, width of each performance counter
WDOG_LIMIT, 1024, consecutive frozen-PC cycles that set deadlock (must be >= 2 and < 2^CNT_W)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
hazard_detect  input  1  RAW stall request from the ID stage
branch_taken  input  1  taken branch resolved in EXE
mem_r_en  input  1  MEM-stage load request
mem_w_en  input  1  MEM-stage store request
mem_ready  input  1  cache/SRAM access complete this cycle
perf_clr  input  1  synchronous clear of the counters and the deadlock flag
freeze_pc  output  1  hold PC
freeze_if_id  output  1  hold IF/ID register
bubble_id_exe  output  1  load a NOP into ID/EXE
freeze_all  output  1  hold ID/EXE, EXE/MEM and MEM/WB
flush_if_id  output  1  clear IF/ID
flush_id_exe  output  1  clear ID/EXE
state  output  2  RUN=0, HAZARD=1, MEM_WAIT=2, FLUSH=3 (registered)
stall_cnt  output  CNT_W  hazard-stall cycles
miss_cnt  output  CNT_W  memory-wait cycles
flush_cnt  output  CNT_W  flush events
deadlock  output  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state=RUN; all counters=0; run_len=0; deadlock=0. All combinational outputs are forced to 0 while rst=0.
- Combinational control, zero latency, fixed priority memory > branch > hazard:
  - mem_busy = (mem_r_en | mem_w_en) & ~mem_ready
  - flush = branch_taken & ~mem_busy
  - hz = hazard_detect & ~mem_busy & ~branch_taken. The branch squashes the stalled ID instruction, so the hazard is dropped.
  - freeze_all = mem_busy
  - freeze_pc = freeze_if_id = mem_busy | hz
  - bubble_id_exe = hz
  - flush_if_id = flush_id_exe = flush
- While mem_busy=1, no flush or bubble is issued, even if branch_taken or hazard_detect is high. EXE is frozen, so branch_taken persists and the flush is issued on the first non-busy cycle, exactly once.
- A read or write with mem_ready=1 in the same cycle is a hit: no freeze.
- State register, next value each clock edge: MEM_WAIT if mem_busy; else FLUSH if flush; else HAZARD if hz; else RUN. Every state can reach every other state directly.
- Counters (registered, saturate at all-ones, never wrap):
  - miss_cnt +1 per mem_busy cycle.
  - stall_cnt +1 per hz cycle.
  - flush_cnt +1 per flush cycle.
  - perf_clr=1 zeroes all three and deadlock, overriding same-cycle increments.
- Watchdog: run_len counts consecutive cycles with freeze_pc=1 and resets to 0 on any cycle with freeze_pc=0. When run_len reaches WDOG_LIMIT-1 with freeze_pc still 1, deadlock sets on that edge (so deadlock rises after WDOG_LIMIT consecutive frozen cycles). run_len saturates at WDOG_LIMIT. deadlock stays set until perf_clr or reset. perf_clr does not clear run_len.
- Reset mid-stall: all outputs drop to 0 immediately. After reset release, behaviour resumes from RUN with the counters at 0.

Test Plan:
- Reset release, all inputs 0 for 5 cycles -> every output 0, state=RUN, counters 0.
- hazard_detect=1 for 2 cycles -> freeze_pc=freeze_if_id=bubble_id_exe=1 both cycles; state=HAZARD on the next 2 edges; stall_cnt=2; flush outputs 0.
- mem_r_en=1, mem_ready=0 for 3 cycles then 1 -> freeze_all=freeze_pc=1 for 3 cycles and 0 in the ready cycle; miss_cnt=3; state MEM_WAIT then RUN.
- branch_taken=1 and hazard_detect=1 together, both held 1 through a 2-cycle miss (mem_w_en=1, mem_ready=0) -> no flush during the miss; flush_if_id=flush_id_exe=1 exactly in the first ready cycle; bubble_id_exe=0; flush_cnt=1.
- CNT_W=4, 20 hazard cycles -> stall_cnt saturates at 15; perf_clr pulse -> stall_cnt=0 on the next edge.
- WDOG_LIMIT=8, mem_busy held 8 cycles -> deadlock=1 after the 8th edge and stays 1 after mem_ready; a 7-cycle run followed by 1 free cycle -> deadlock stays 0.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall controller.
// Turns the ID hazard request, the EXE taken branch and the MEM ready signal
// into freeze, bubble and flush controls. The fixed priority is
// memory > branch > hazard. It also tracks the pipeline condition in a
// registered state, keeps saturating performance counters and runs a sticky
// watchdog on long PC freezes.
//
// Ports:
//   clk, rst (async, active-low)
//   hazard_detect, branch_taken       - stall / redirect requests
//   mem_r_en, mem_w_en, mem_ready     - MEM-stage access and completion
//   perf_clr                          - sync clear of counters and deadlock
//   freeze_pc, freeze_if_id           - hold PC and IF/ID
//   bubble_id_exe                     - NOP into ID/EXE
//   freeze_all                        - hold ID/EXE, EXE/MEM, MEM/WB
//   flush_if_id, flush_id_exe         - squash the wrong-path instructions
//   state                             - RUN=0, HAZARD=1, MEM_WAIT=2, FLUSH=3
//   stall_cnt, miss_cnt, flush_cnt    - saturating event counters
//   deadlock                          - sticky watchdog flag
module pipeline_stall_controller #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detect,
    input  logic             branch_taken,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             mem_ready,
    input  logic             perf_clr,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_exe,
    output logic             freeze_all,
    output logic             flush_if_id,
    output logic             flush_id_exe,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             deadlock
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StHazard  = 2'd1,
        StMemWait = 2'd2,
        StFlush   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] WdogMax  = CNT_W'(WDOG_LIMIT);
    localparam logic [CNT_W-1:0] WdogTrip = CNT_W'(WDOG_LIMIT - 1);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             deadlock_q, deadlock_d;

    logic mem_busy, flush, hz, pc_hold;

    // A busy memory freezes EXE, so a pending branch holds until it is
    // released. A taken branch squashes the stalled ID instruction, so the
    // hazard is dropped.
    assign mem_busy = (mem_r_en | mem_w_en) & ~mem_ready;
    assign flush    = branch_taken & ~mem_busy;
    assign hz       = hazard_detect & ~mem_busy & ~branch_taken;
    assign pc_hold  = mem_busy | hz;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && v != CntMax) ? v + 1'b1 : v;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = StRun;
        if (mem_busy) begin
            state_d = StMemWait;
        end else if (flush) begin
            state_d = StFlush;
        end else if (hz) begin
            state_d = StHazard;
        end
    end

    // Control outputs are forced low while reset is held.
    always_comb begin
        freeze_all    = 1'b0;
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_exe  = 1'b0;
        if (rst) begin
            freeze_all    = mem_busy;
            freeze_pc     = pc_hold;
            freeze_if_id  = pc_hold;
            bubble_id_exe = hz;
            flush_if_id   = flush;
            flush_id_exe  = flush;
        end
    end

    // Counters and watchdog next state
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, hz);
        miss_cnt_d  = sat_inc(miss_cnt_q, mem_busy);
        flush_cnt_d = sat_inc(flush_cnt_q, flush);
        deadlock_d  = deadlock_q;
        run_len_d   = '0;

        if (pc_hold) begin
            run_len_d = (run_len_q < WdogMax) ? run_len_q + 1'b1 : run_len_q;
            if (run_len_q == WdogTrip) begin
                deadlock_d = 1'b1;
            end
        end

        // The clear wins over same-cycle increments. run_len is left alone.
        if (perf_clr) begin
            stall_cnt_d = '0;
            miss_cnt_d  = '0;
            flush_cnt_d = '0;
            deadlock_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
            flush_cnt_q <= '0;
            run_len_q   <= '0;
            deadlock_q  <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            run_len_q   <= run_len_d;
            deadlock_q  <= deadlock_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign deadlock  = deadlock_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. It uses CNT_W=4 and
// WDOG_LIMIT=8 so that saturation and the watchdog are reached quickly.
module tb_pipeline_stall_controller;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned WDOG_LIMIT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             hazard_detect = 1'b0;
    logic             branch_taken = 1'b0;
    logic             mem_r_en = 1'b0;
    logic             mem_w_en = 1'b0;
    logic             mem_ready = 1'b0;
    logic             perf_clr = 1'b0;
    logic             freeze_pc, freeze_if_id, bubble_id_exe, freeze_all;
    logic             flush_if_id, flush_id_exe, deadlock;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, miss_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_stall_controller #(
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hazard_detect (hazard_detect),
        .branch_taken  (branch_taken),
        .mem_r_en      (mem_r_en),
        .mem_w_en      (mem_w_en),
        .mem_ready     (mem_ready),
        .perf_clr      (perf_clr),
        .freeze_pc     (freeze_pc),
        .freeze_if_id  (freeze_if_id),
        .bubble_id_exe (bubble_id_exe),
        .freeze_all    (freeze_all),
        .flush_if_id   (flush_if_id),
        .flush_id_exe  (flush_id_exe),
        .state         (state),
        .stall_cnt     (stall_cnt),
        .miss_cnt      (miss_cnt),
        .flush_cnt     (flush_cnt),
        .deadlock      (deadlock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs then settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack the six control outputs:
    // {freeze_pc, freeze_if_id, bubble, freeze_all, flush_if_id, flush_id_exe}
    function automatic logic [31:0] ctl();
        return {26'd0, freeze_pc, freeze_if_id, bubble_id_exe, freeze_all,
                flush_if_id, flush_id_exe};
    endfunction

    initial begin
        // Requests raised while in reset must not leak out.
        hazard_detect = 1'b1;
        mem_r_en      = 1'b1;
        #1;
        check("rst_ctl", ctl(), 32'h00);
        check("rst_state", 32'(state), 32'd0);
        hazard_detect = 1'b0;
        mem_r_en      = 1'b0;
        #20;
        rst = 1'b1;

        // Idle for 5 cycles
        for (int i = 0; i < 5; i++) tick();
        check("idle_ctl", ctl(), 32'h00);
        check("idle_state", 32'(state), 32'd0);
        check("idle_cnts", {20'd0, stall_cnt, miss_cnt, flush_cnt}, 32'd0);
        check("idle_dl", 32'(deadlock), 32'd0);

        // Hazard for 2 cycles
        hazard_detect = 1'b1;
        #1;
        check("hz1_ctl", ctl(), 32'h38);
        tick();
        check("hz1_state", 32'(state), 32'd1);
        check("hz2_ctl", ctl(), 32'h38);
        tick();
        check("hz2_state", 32'(state), 32'd1);
        hazard_detect = 1'b0;
        #1;
        check("hz_stall_cnt", 32'(stall_cnt), 32'd2);
        check("hz_off_ctl", ctl(), 32'h00);
        tick();
        check("hz_back_run", 32'(state), 32'd0);

        // Read miss for 3 cycles, then ready
        mem_r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("miss_ctl", ctl(), 32'h34);
            tick();
            check("miss_state", 32'(state), 32'd2);
        end
        mem_ready = 1'b1;
        #1;
        check("hit_ctl", ctl(), 32'h00);
        tick();
        check("hit_state", 32'(state), 32'd0);
        check("miss_cnt3", 32'(miss_cnt), 32'd3);
        mem_r_en  = 1'b0;
        mem_ready = 1'b0;

        // Branch and hazard held through a 2-cycle write miss
        mem_w_en      = 1'b1;
        branch_taken  = 1'b1;
        hazard_detect = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("br_miss_ctl", ctl(), 32'h34);
            tick();
        end
        check("br_miss_state", 32'(state), 32'd2);
        mem_ready = 1'b1;
        #1;
        check("br_flush_ctl", ctl(), 32'h03);
        tick();
        check("br_flush_state", 32'(state), 32'd3);
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd2);
        branch_taken  = 1'b0;
        hazard_detect = 1'b0;
        mem_w_en      = 1'b0;
        mem_ready     = 1'b0;
        tick();
        check("br_after_state", 32'(state), 32'd0);
        check("br_after_flush_cnt", 32'(flush_cnt), 32'd1);

        // Watchdog: a 7-cycle freeze followed by a free cycle must not trip it.
        mem_r_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        mem_r_en = 1'b0;
        tick();
        check("wd7_dl", 32'(deadlock), 32'd0);
        // An 8-cycle freeze trips it on the 8th edge.
        mem_r_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("wd_edge7_dl", 32'(deadlock), 32'd0);
        tick();
        check("wd_edge8_dl", 32'(deadlock), 32'd1);
        mem_ready = 1'b1;
        tick();
        check("wd_sticky_dl", 32'(deadlock), 32'd1);
        // 5 + 7 + 8 busy cycles: the counter holds at all-ones.
        check("miss_sat", 32'(miss_cnt), 32'd15);
        mem_r_en  = 1'b0;
        mem_ready = 1'b0;

        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        check("clr_cnts", {20'd0, stall_cnt, miss_cnt, flush_cnt}, 32'd0);
        check("clr_dl", 32'(deadlock), 32'd0);

        // 20 hazard cycles saturate stall_cnt at 15.
        hazard_detect = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("stall_sat", 32'(stall_cnt), 32'd15);
        check("hz_wd_dl", 32'(deadlock), 32'd1);
        // The clear wins over a same-cycle increment.
        perf_clr = 1'b1;
        tick();
        perf_clr      = 1'b0;
        hazard_detect = 1'b0;
        check("clr_over_inc", 32'(stall_cnt), 32'd0);
        check("clr_dl2", 32'(deadlock), 32'd0);
        tick();
        check("stall_idle", 32'(stall_cnt), 32'd0);

        // Reset in the middle of a stall
        hazard_detect = 1'b1;
        tick();
        tick();
        check("pre_rst_cnt", 32'(stall_cnt), 32'd2);
        rst = 1'b0;
        #1;
        check("mid_rst_ctl", ctl(), 32'h00);
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        hazard_detect = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        check("post_rst_state", 32'(state), 32'd0);
        check("post_rst_cnt", 32'(stall_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
